qcw_burst_sequencer: RTL and testbench

//   Sequences one QCW burst of the gate-drive oscillator. On a trigger it loads period and a

---
 rtl/qcw_burst_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_qcw_burst_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qcw_burst_sequencer.sv
// QCW burst sequencer: arms qcw_osc with period/phase, ramps the B-leg phase during the
// burst, then drains, enforces a holdoff, and latches hard faults until they are cleared.
module qcw_burst_sequencer #(
  parameter int unsigned W            = 24,
  parameter int unsigned DRAIN_CYCLES = 16
) (
  input  logic         clk_logic,
  input  logic         reset,
  input  logic [W-1:0] cfg_period,
  input  logic [W-1:0] cfg_phase_start,
  input  logic [W-1:0] cfg_phase_end,
  input  logic [W-1:0] cfg_phase_step,
  input  logic [W-1:0] cfg_ramp_div,
  input  logic [W-1:0] cfg_burst_len,
  input  logic [W-1:0] cfg_holdoff,
  input  logic         trigger,
  input  logic         abort,
  input  logic         fault,
  input  logic         fault_clear,
  output logic [W-1:0] osc_period,
  output logic [W-1:0] osc_b_phase,
  output logic         osc_latch,
  output logic         osc_enable,
  output logic         busy,
  output logic         burst_done,
  output logic         fault_latched
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_RUN, S_STOP, S_HOLDOFF, S_FAULT
  } state_t;

  localparam logic [W-1:0] DRAIN = W'(DRAIN_CYCLES);
  localparam logic [W-1:0] ONE   = W'(1);

  state_t state_q, state_d;

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] ramp_q, ramp_d;

  logic [W-1:0] sh_period_q, sh_period_d;
  logic [W-1:0] sh_start_q, sh_start_d;
  logic [W-1:0] sh_end_q, sh_end_d;
  logic [W-1:0] sh_step_q, sh_step_d;
  logic [W-1:0] sh_div_q, sh_div_d;
  logic [W-1:0] sh_len_q, sh_len_d;
  logic [W-1:0] sh_holdoff_q, sh_holdoff_d;

  logic [W-1:0] osc_period_q, osc_period_d;
  logic [W-1:0] osc_b_phase_q, osc_b_phase_d;
  logic         osc_latch_q, osc_latch_d;
  logic         osc_enable_q, osc_enable_d;
  logic         busy_q, busy_d;
  logic         burst_done_q, burst_done_d;
  logic         fault_latched_q, fault_latched_d;

  logic [W:0]   phase_sum;
  logic [W-1:0] phase_tgt;
  logic [W-1:0] phase_next;
  logic         ramp_live;

  always_ff @(posedge clk_logic) begin
    if (reset) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      ramp_q          <= '0;
      sh_period_q     <= '0;
      sh_start_q      <= '0;
      sh_end_q        <= '0;
      sh_step_q       <= '0;
      sh_div_q        <= '0;
      sh_len_q        <= '0;
      sh_holdoff_q    <= '0;
      osc_period_q    <= '0;
      osc_b_phase_q   <= '0;
      osc_latch_q     <= 1'b0;
      osc_enable_q    <= 1'b0;
      busy_q          <= 1'b0;
      burst_done_q    <= 1'b0;
      fault_latched_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      ramp_q          <= ramp_d;
      sh_period_q     <= sh_period_d;
      sh_start_q      <= sh_start_d;
      sh_end_q        <= sh_end_d;
      sh_step_q       <= sh_step_d;
      sh_div_q        <= sh_div_d;
      sh_len_q        <= sh_len_d;
      sh_holdoff_q    <= sh_holdoff_d;
      osc_period_q    <= osc_period_d;
      osc_b_phase_q   <= osc_b_phase_d;
      osc_latch_q     <= osc_latch_d;
      osc_enable_q    <= osc_enable_d;
      busy_q          <= busy_d;
      burst_done_q    <= burst_done_d;
      fault_latched_q <= fault_latched_d;
    end
  end

  // cnt_q is 1 on the first cycle of every state, so ">=" also covers len/holdoff of 0
  always_comb begin
    state_d = state_q;
    if (fault) begin
      state_d = S_FAULT;
    end else begin
      case (state_q)
        S_IDLE:    if (trigger) state_d = S_ARM;
        S_ARM:     state_d = abort ? S_STOP : S_RUN;
        S_RUN:     if (abort || cnt_q >= sh_len_q) state_d = S_STOP;
        S_STOP:    if (cnt_q >= DRAIN) state_d = S_HOLDOFF;
        S_HOLDOFF: if (cnt_q >= sh_holdoff_q) state_d = S_IDLE;
        S_FAULT:   if (fault_clear) state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state, so each value is visible in the state it belongs to
  always_comb begin
    cnt_d           = (state_d != state_q) ? ONE : cnt_q + ONE;
    ramp_d          = ramp_q;
    sh_period_d     = sh_period_q;
    sh_start_d      = sh_start_q;
    sh_end_d        = sh_end_q;
    sh_step_d       = sh_step_q;
    sh_div_d        = sh_div_q;
    sh_len_d        = sh_len_q;
    sh_holdoff_d    = sh_holdoff_q;
    osc_period_d    = osc_period_q;
    osc_b_phase_d   = osc_b_phase_q;
    osc_latch_d     = 1'b0;
    osc_enable_d    = 1'b0;
    burst_done_d    = 1'b0;
    fault_latched_d = 1'b0;
    busy_d          = (state_d != S_IDLE);

    phase_tgt  = (sh_end_q < sh_period_q) ? sh_end_q : sh_period_q;
    phase_sum  = {1'b0, osc_b_phase_q} + {1'b0, sh_step_q};
    phase_next = (phase_sum > {1'b0, phase_tgt}) ? phase_tgt : phase_sum[W-1:0];
    ramp_live  = (sh_start_q < sh_end_q) && (osc_b_phase_q < phase_tgt);

    case (state_d)
      S_ARM: begin
        sh_period_d   = cfg_period;
        sh_start_d    = cfg_phase_start;
        sh_end_d      = cfg_phase_end;
        sh_step_d     = cfg_phase_step;
        sh_div_d      = cfg_ramp_div;
        sh_len_d      = cfg_burst_len;
        sh_holdoff_d  = cfg_holdoff;
        osc_period_d  = cfg_period;
        osc_b_phase_d = (cfg_phase_start < cfg_period) ? cfg_phase_start : cfg_period;
        osc_latch_d   = 1'b1;
      end
      S_RUN: begin
        osc_enable_d = 1'b1;
        if (state_q != S_RUN) begin
          ramp_d = '0;
        end else if (ramp_q == sh_div_q) begin
          ramp_d = '0;
          if (ramp_live) begin
            osc_b_phase_d = phase_next;
            osc_latch_d   = 1'b1;
          end
        end else begin
          ramp_d = ramp_q + ONE;
        end
      end
      S_HOLDOFF: burst_done_d    = (state_q == S_STOP);
      S_FAULT:   fault_latched_d = 1'b1;
      default: ;
    endcase
  end

  assign osc_period    = osc_period_q;
  assign osc_b_phase   = osc_b_phase_q;
  assign osc_latch     = osc_latch_q;
  assign osc_enable    = osc_enable_q;
  assign busy          = busy_q;
  assign burst_done    = burst_done_q;
  assign fault_latched = fault_latched_q;

endmodule

// File: tb/tb_qcw_burst_sequencer.sv
// Bench for qcw_burst_sequencer: a burst-timeline model (offset from ARM, closed-form phase)
// checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_qcw_burst_sequencer;
  localparam int W = 24;
  localparam int D = 16;

  logic clk_logic = 1'b0;
  always #5 clk_logic = ~clk_logic;

  logic         reset, trigger, abort, fault, fault_clear;
  logic [W-1:0] cfg_period, cfg_phase_start, cfg_phase_end, cfg_phase_step;
  logic [W-1:0] cfg_ramp_div, cfg_burst_len, cfg_holdoff;
  logic [W-1:0] osc_period, osc_b_phase;
  logic         osc_latch, osc_enable, busy, burst_done, fault_latched;

  int n_checks = 0;
  int n_fail   = 0;

  qcw_burst_sequencer #(.W(W), .DRAIN_CYCLES(D)) dut (
    .clk_logic      (clk_logic),
    .reset          (reset),
    .cfg_period     (cfg_period),
    .cfg_phase_start(cfg_phase_start),
    .cfg_phase_end  (cfg_phase_end),
    .cfg_phase_step (cfg_phase_step),
    .cfg_ramp_div   (cfg_ramp_div),
    .cfg_burst_len  (cfg_burst_len),
    .cfg_holdoff    (cfg_holdoff),
    .trigger        (trigger),
    .abort          (abort),
    .fault          (fault),
    .fault_clear    (fault_clear),
    .osc_period     (osc_period),
    .osc_b_phase    (osc_b_phase),
    .osc_latch      (osc_latch),
    .osc_enable     (osc_enable),
    .busy           (busy),
    .burst_done     (burst_done),
    .fault_latched  (fault_latched)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: burst described by offset e from the ARM cycle ----------
  int     m_mode = 0;  // 0 idle, 1 in burst (ARM..HOLDOFF), 2 fault
  longint m_e = 0, m_stop = 0, m_H = 1;
  longint m_per = 0, m_st = 0, m_en = 0, m_stp = 0, m_div = 0;
  longint ex_period = 0, ex_phase = 0;
  bit     ex_latch, ex_en, ex_busy, ex_done, ex_flt;

  function automatic longint lmin(input longint a, input longint b);
    return (a < b) ? a : b;
  endfunction

  // phase shown in RUN cycle k: one tick lands every div+1 cycles, clipped at min(end, period)
  function automatic longint phase_at(input longint k);
    longint p0, n;
    p0 = lmin(m_st, m_per);
    if (k < 1 || m_st >= m_en) return p0;
    n = (k - 1) / (m_div + 1);
    return lmin(p0 + n * m_stp, lmin(m_en, m_per));
  endfunction

  function automatic bit latch_at(input longint k);
    if (k < 2 || m_st >= m_en) return 1'b0;
    if (((k - 1) % (m_div + 1)) != 0) return 1'b0;
    return phase_at(k - 1) < lmin(m_en, m_per);
  endfunction

  always @(posedge clk_logic) begin
    if (reset) begin
      m_mode = 0; ex_period = 0; ex_phase = 0;
    end else if (fault) begin
      m_mode = 2;
    end else begin
      case (m_mode)
        0: if (trigger) begin
          m_per = cfg_period; m_st = cfg_phase_start; m_en = cfg_phase_end;
          m_stp = cfg_phase_step; m_div = cfg_ramp_div;
          m_H = (cfg_holdoff == 0) ? 1 : longint'(cfg_holdoff);
          m_stop = ((cfg_burst_len == 0) ? 1 : longint'(cfg_burst_len)) + 1;
          m_e = 0; m_mode = 1;
        end
        1: begin
          if (abort && m_e < m_stop) m_stop = m_e + 1;
          m_e++;
          if (m_e >= m_stop + D + m_H) m_mode = 0;
        end
        default: if (fault_clear) m_mode = 0;
      endcase
    end
    ex_latch = 0; ex_en = 0; ex_busy = 0; ex_done = 0; ex_flt = 0;
    if (m_mode == 1) begin
      ex_busy  = 1;
      ex_en    = (m_e >= 1) && (m_e < m_stop);
      ex_done  = (m_e == m_stop + D);
      ex_latch = (m_e == 0) || (ex_en && latch_at(m_e));
      if (m_e == 0) ex_period = m_per;
      ex_phase = phase_at(lmin(m_e, m_stop - 1));
    end else if (m_mode == 2) begin
      ex_busy = 1; ex_flt = 1;
    end
    #1;
    chk("model_osc_period", osc_period, ex_period);
    chk("model_osc_b_phase", osc_b_phase, ex_phase);
    chk("model_osc_latch", osc_latch, ex_latch);
    chk("model_osc_enable", osc_enable, ex_en);
    chk("model_busy", busy, ex_busy);
    chk("model_burst_done", burst_done, ex_done);
    chk("model_fault_latched", fault_latched, ex_flt);
  end

  // ---------------- stimulus helpers (all return on a falling edge) ----------------
  task automatic nclk(input int n);
    repeat (n) @(negedge clk_logic);
  endtask

  task automatic set_cfg(input logic [W-1:0] per, st, en, stp, dv, len, ho);
    cfg_period = per; cfg_phase_start = st; cfg_phase_end = en; cfg_phase_step = stp;
    cfg_ramp_div = dv; cfg_burst_len = len; cfg_holdoff = ho;
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    nclk(1);
    trigger = 1'b0;
  endtask

  function automatic bit sig(input int which);
    case (which)
      0:       return burst_done;
      1:       return osc_latch;
      2:       return osc_enable;
      3:       return !osc_enable;
      default: return !busy;
    endcase
  endfunction

  task automatic count_until(input int which, input int bound, output int cyc);
    cyc = -1;
    for (int i = 1; i <= bound; i++) begin
      nclk(1);
      if (sig(which)) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic wait_idle(input string name, input int bound);
    int c;
    count_until(4, bound, c);
    chk(name, c > 0, 1);
  endtask

  task automatic rand_cfg();
    cfg_period      = W'($urandom_range(1000, 20));
    cfg_phase_start = W'($urandom_range(1100));
    cfg_phase_end   = W'($urandom_range(1100));
    cfg_phase_step  = ($urandom_range(7) == 0) ? '1 : W'($urandom_range(300));
    cfg_ramp_div    = W'($urandom_range(7));
    cfg_burst_len   = W'($urandom_range(40));
    cfg_holdoff     = W'($urandom_range(8));
  endtask

  initial begin
    int c, en_cnt, lat_cnt;
    reset = 1'b1; trigger = 0; abort = 0; fault = 0; fault_clear = 0;
    set_cfg(1000, 100, 400, 100, 9, 50, 20);
    nclk(3);
    chk("reset_busy", busy, 0);
    chk("reset_osc_period", osc_period, 0);
    chk("reset_enable", osc_enable, 0);
    reset = 1'b0;
    nclk(2);

    // basic ramp
    pulse_trigger();
    chk("t1_arm_latch", osc_latch, 1);
    chk("t1_arm_phase", osc_b_phase, 100);
    chk("t1_arm_period", osc_period, 1000);
    chk("t1_arm_enable", osc_enable, 0);
    en_cnt = 0; lat_cnt = 0;
    for (int k = 1; k <= 60; k++) begin
      nclk(1);
      en_cnt += int'(osc_enable);
      lat_cnt += int'(osc_latch);
      if (k == 11) chk("t1_phase_tick10", osc_b_phase, 200);
      if (k == 21) chk("t1_phase_tick20", osc_b_phase, 300);
      if (k == 31) chk("t1_phase_tick30", osc_b_phase, 400);
      if (k == 31) chk("t1_latch_tick30", osc_latch, 1);
      if (k == 41) chk("t1_no_latch_tick40", osc_latch, 0);
    end
    chk("t1_enable_cycles", en_cnt, 50);
    chk("t1_ramp_latches", lat_cnt, 3);
    wait_idle("t1_idle", 100);

    // trigger held: drain, holdoff, re-arm
    trigger = 1'b1;
    count_until(2, 10, c);  chk("t2_enable_start", c, 2);
    count_until(3, 100, c); chk("t2_enable_len", c, 50);
    count_until(0, 40, c);  chk("t2_drain_len", c, 16);
    count_until(1, 40, c);  chk("t2_holdoff_to_arm", c, 21);
    trigger = 1'b0;
    wait_idle("t2_idle", 200);

    // fault mid-RUN
    pulse_trigger();
    nclk(25);
    fault = 1'b1;
    nclk(1);
    chk("t3_enable_off", osc_enable, 0);
    chk("t3_fault_latched", fault_latched, 1);
    chk("t3_phase_hold", osc_b_phase, 300);
    fault_clear = 1'b1;
    nclk(3);
    chk("t3_clear_ignored", fault_latched, 1);
    fault = 1'b0;
    nclk(1);
    chk("t3_cleared_busy", busy, 0);
    chk("t3_cleared_flag", fault_latched, 0);
    fault_clear = 1'b0;
    nclk(2);

    // abort, then abort coinciding with fault
    pulse_trigger();
    nclk(5);
    abort = 1'b1;
    nclk(1);
    abort = 1'b0;
    chk("t4_abort_enable_off", osc_enable, 0);
    count_until(0, 40, c); chk("t4_abort_drain", c, 16);
    wait_idle("t4_idle", 100);
    pulse_trigger();
    nclk(3);
    abort = 1'b1; fault = 1'b1;
    nclk(1);
    abort = 1'b0; fault = 1'b0;
    chk("t4_fault_wins", fault_latched, 1);
    fault_clear = 1'b1;
    nclk(1);
    fault_clear = 1'b0;
    chk("t4_fault_exit", busy, 0);

    // saturation without wrap, then start > end
    set_cfg(1000, 100, '1, '1, 0, 10, 0);
    pulse_trigger();
    lat_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      nclk(1);
      lat_cnt += int'(osc_latch);
      if (k == 2) chk("t5_sat_first", osc_b_phase, 1000);
    end
    chk("t5_sat_last", osc_b_phase, 1000);
    chk("t5_sat_latches", lat_cnt, 1);
    wait_idle("t5_idle_a", 60);
    set_cfg(1000, 500, 200, 50, 0, 10, 0);
    pulse_trigger();
    chk("t5_rev_arm_phase", osc_b_phase, 500);
    lat_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      nclk(1);
      lat_cnt += int'(osc_latch);
    end
    chk("t5_rev_latches", lat_cnt, 0);
    chk("t5_rev_phase", osc_b_phase, 500);
    wait_idle("t5_idle_b", 60);

    // len = 0, cfg change mid-burst, reset mid-RUN
    set_cfg(1000, 100, 400, 100, 0, 0, 0);
    pulse_trigger();
    en_cnt = 0;
    for (int k = 1; k <= 5; k++) begin
      nclk(1);
      en_cnt += int'(osc_enable);
    end
    chk("t6_len0_enable", en_cnt, 1);
    wait_idle("t6_idle_a", 60);
    set_cfg(1000, 100, 400, 100, 9, 50, 20);
    pulse_trigger();
    nclk(2);
    set_cfg(300, 7, 9, 1, 0, 3, 0);
    nclk(9);
    chk("t6_cfg_shadow_phase", osc_b_phase, 200);
    chk("t6_cfg_shadow_enable", osc_enable, 1);
    wait_idle("t6_idle_b", 150);
    set_cfg(1000, 100, 400, 100, 9, 50, 20);
    pulse_trigger();
    nclk(10);
    reset = 1'b1;
    nclk(1);
    chk("t6_rst_period", osc_period, 0);
    chk("t6_rst_phase", osc_b_phase, 0);
    chk("t6_rst_enable", osc_enable, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_latch", osc_latch, 0);
    reset = 1'b0;
    nclk(2);

    // randomized traffic, checked by the model
    rand_cfg();
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(99) < 5) rand_cfg();
      trigger     = ($urandom_range(99) < 20);
      abort       = ($urandom_range(199) < 3);
      fault       = ($urandom_range(499) < 3);
      fault_clear = ($urandom_range(99) < 10);
      reset       = ($urandom_range(999) < 2);
      nclk(1);
    end
    trigger = 0; abort = 0; fault = 0; reset = 0; fault_clear = 1'b1;
    nclk(3);
    fault_clear = 1'b0;
    nclk(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
